// File: rtl/hamming_decoder.sv
// Byte-serial SECDED decoder for 16-bit Hamming codewords carrying 11 data bits.
// Takes two codeword bytes in, then returns the corrected data and error flags as two bytes.
module hamming_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [7:0]       InByte,
    input  logic             InValid,
    output logic             InReady,
    output logic [7:0]       OutByte,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [CNT_W-1:0] SingleCnt,
    output logic [CNT_W-1:0] DoubleCnt,
    output logic             Busy
);

    typedef enum logic [2:0] {
        ST_GET_LO  = 3'd0,
        ST_GET_HI  = 3'd1,
        ST_CALC    = 3'd2,
        ST_SEND_LO = 3'd3,
        ST_SEND_HI = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_code;
    logic [7:0]       r_hi;
    logic [7:0]       r_out_byte;
    logic [CNT_W-1:0] r_single;
    logic [CNT_W-1:0] r_double;

    logic [3:0]       w_syn;
    logic             w_par;
    logic [15:0]      w_flip;
    logic [10:0]      w_data;
    logic             w_single;
    logic             w_double;

    // Syndrome bit k covers every position whose index has bit k set.
    function automatic logic [3:0] calc_syndrome(input logic [15:0] cw);
        calc_syndrome[0] = ^(cw & 16'hAAAA);
        calc_syndrome[1] = ^(cw & 16'hCCCC);
        calc_syndrome[2] = ^(cw & 16'hF0F0);
        calc_syndrome[3] = ^(cw & 16'hFF00);
    endfunction

    function automatic logic calc_parity(input logic [15:0] cw);
        calc_parity = ^cw;
    endfunction

    function automatic logic [10:0] extract_data(input logic [15:0] cw);
        extract_data = {cw[15], cw[14], cw[13], cw[12], cw[11], cw[10],
                        cw[9], cw[7], cw[6], cw[5], cw[3]};
    endfunction

    assign w_syn    = calc_syndrome(r_code);
    assign w_par    = calc_parity(r_code);
    assign w_single = w_par;
    assign w_double = !w_par && (w_syn != 4'd0);

    // Odd overall parity means one flipped bit at position w_syn (0 = the overall parity bit).
    always_comb begin
        w_flip = 16'h0000;
        if (w_par) begin
            w_flip = 16'h0001 << w_syn;
        end else begin
            w_flip = 16'h0000;
        end
    end

    assign w_data = extract_data(r_code ^ w_flip);

    // Next-state logic for the receive / compute / send sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_GET_LO: begin
                if (InValid) w_next = ST_GET_HI;
                else         w_next = ST_GET_LO;
            end
            ST_GET_HI: begin
                if (InValid) w_next = ST_CALC;
                else         w_next = ST_GET_HI;
            end
            ST_CALC:   w_next = ST_SEND_LO;
            ST_SEND_LO: begin
                if (OutReady) w_next = ST_SEND_HI;
                else          w_next = ST_SEND_LO;
            end
            ST_SEND_HI: begin
                if (OutReady) w_next = ST_GET_LO;
                else          w_next = ST_SEND_HI;
            end
            default:   w_next = ST_GET_LO;
        endcase
    end

    // State, captured codeword, result bytes and saturating error counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_GET_LO;
            r_code     <= 16'h0000;
            r_hi       <= 8'h00;
            r_out_byte <= 8'h00;
            r_single   <= {CNT_W{1'b0}};
            r_double   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_GET_LO: if (InValid) r_code[7:0]  <= InByte;
                ST_GET_HI: if (InValid) r_code[15:8] <= InByte;
                ST_CALC: begin
                    r_out_byte <= w_data[7:0];
                    r_hi       <= {w_double, w_single, 3'b000, w_data[10:8]};
                    if (w_single && (r_single != CNT_MAX)) r_single <= r_single + CNT_ONE;
                    if (w_double && (r_double != CNT_MAX)) r_double <= r_double + CNT_ONE;
                end
                ST_SEND_LO: if (OutReady) r_out_byte <= r_hi;
                ST_SEND_HI: if (OutReady) r_out_byte <= 8'h00;
                default: begin
                end
            endcase
        end
    end

    assign InReady   = (r_state == ST_GET_LO) || (r_state == ST_GET_HI);
    assign OutValid  = (r_state == ST_SEND_LO) || (r_state == ST_SEND_HI);
    assign OutByte   = r_out_byte;
    assign Busy      = (r_state != ST_GET_LO);
    assign SingleCnt = r_single;
    assign DoubleCnt = r_double;

endmodule

// File: tb/tb_hamming_decoder.sv
// Bench for hamming_decoder: directed cases plus random codewords with 0-2 injected errors,
// checked against a position-arithmetic SECDED model.
module tb_hamming_decoder;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] InByte;
    logic       InValid;
    logic       InReady;
    logic [7:0] OutByte;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] SingleCnt;
    logic [7:0] DoubleCnt;
    logic       Busy;

    int n_checks = 0;
    int n_errors = 0;
    int exp_single = 0;
    int exp_double = 0;
    int dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    hamming_decoder #(.CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .InByte(InByte), .InValid(InValid), .InReady(InReady),
        .OutByte(OutByte), .OutValid(OutValid), .OutReady(OutReady),
        .SingleCnt(SingleCnt), .DoubleCnt(DoubleCnt), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Builds a clean codeword: parity bits chosen so the XOR of set positions is zero.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        int s;
        c = 16'h0000;
        for (int i = 0; i < 11; i++) c[dpos[i]] = d[i];
        s = 0;
        for (int p = 0; p < 16; p++) if (c[p]) s = s ^ p;
        c[1] = s[0];
        c[2] = s[1];
        c[4] = s[2];
        c[8] = s[3];
        c[0] = ^c;
        return c;
    endfunction

    // Returns {hi, lo} output bytes expected for a received codeword.
    function automatic logic [15:0] model_decode(input logic [15:0] cw);
        logic [15:0] c;
        logic [10:0] d;
        logic [1:0]  f;
        int s;
        int p;
        c = cw;
        s = 0;
        p = 0;
        for (int i = 0; i < 16; i++) if (c[i]) begin s = s ^ i; p = p ^ 1; end
        if (p == 1) begin
            c[s] = ~c[s];
            f = 2'b01;
        end else if (s != 0) begin
            f = 2'b10;
        end else begin
            f = 2'b00;
        end
        for (int i = 0; i < 11; i++) d[i] = c[dpos[i]];
        return {f, 3'b000, d[10:8], d[7:0]};
    endfunction

    task automatic run_word(input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] exp_lo, input logic [7:0] exp_hi, input int stall);
        int t;
        @(negedge Clk);
        t = 0;
        while (!InReady && t < 10) begin @(negedge Clk); t++; end
        check("in_ready_lo", {31'd0, InReady}, 32'd1);
        InByte  = lo;
        InValid = 1'b1;
        @(negedge Clk);
        check("in_ready_hi", {31'd0, InReady}, 32'd1);
        InByte = hi;
        @(negedge Clk);
        InValid = 1'b0;
        check("calc_out_valid", {31'd0, OutValid}, 32'd0);
        check("calc_in_ready", {31'd0, InReady}, 32'd0);
        @(negedge Clk);
        check("out_valid_lo", {31'd0, OutValid}, 32'd1);
        check("out_lo", {24'd0, OutByte}, {24'd0, exp_lo});
        for (int i = 0; i < stall; i++) begin
            OutReady = 1'b0;
            InValid  = 1'b1;
            InByte   = 8'hA5;
            @(negedge Clk);
            check("hold_lo", {24'd0, OutByte}, {24'd0, exp_lo});
            check("hold_valid", {31'd0, OutValid}, 32'd1);
            check("hold_in_ready", {31'd0, InReady}, 32'd0);
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        @(negedge Clk);
        check("out_valid_hi", {31'd0, OutValid}, 32'd1);
        check("out_hi", {24'd0, OutByte}, {24'd0, exp_hi});
        @(negedge Clk);
        OutReady = 1'b0;
        if (exp_hi[6]) exp_single = (exp_single == 255) ? 255 : exp_single + 1;
        if (exp_hi[7]) exp_double = (exp_double == 255) ? 255 : exp_double + 1;
        check("idle_valid", {31'd0, OutValid}, 32'd0);
        check("idle_busy", {31'd0, Busy}, 32'd0);
        check("single_cnt", {24'd0, SingleCnt}, exp_single);
        check("double_cnt", {24'd0, DoubleCnt}, exp_double);
    endtask

    task automatic check_reset_state();
        check("rst_in_ready", {31'd0, InReady}, 32'd1);
        check("rst_out_valid", {31'd0, OutValid}, 32'd0);
        check("rst_out_byte", {24'd0, OutByte}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_single", {24'd0, SingleCnt}, 32'd0);
        check("rst_double", {24'd0, DoubleCnt}, 32'd0);
    endtask

    initial begin
        logic [15:0] cw;
        logic [15:0] exp;
        int p1;
        int p2;
        int ne;

        Reset    = 1'b1;
        InByte   = 8'h00;
        InValid  = 1'b0;
        OutReady = 1'b0;
        repeat (2) @(negedge Clk);
        check_reset_state();
        Reset = 1'b0;

        run_word(8'h00, 8'h00, 8'h00, 8'h00, 0);
        run_word(8'hFF, 8'hFF, 8'hFF, 8'h07, 0);
        run_word(8'hDF, 8'hFF, 8'hFF, 8'h47, 0);
        run_word(8'hFE, 8'hFF, 8'hFF, 8'h47, 0);
        run_word(8'hD7, 8'hFF, 8'hFC, 8'h87, 0);
        run_word(8'hFF, 8'hFF, 8'hFF, 8'h07, 3);

        // Reset with half a word captured: the low byte must be discarded.
        @(negedge Clk);
        InByte  = 8'h12;
        InValid = 1'b1;
        @(negedge Clk);
        InValid = 1'b0;
        Reset   = 1'b1;
        @(negedge Clk);
        check_reset_state();
        Reset = 1'b0;
        exp_single = 0;
        exp_double = 0;
        run_word(8'hDF, 8'hFF, 8'hFF, 8'h47, 0);

        for (int n = 0; n < 200; n++) begin
            cw = encode(11'($urandom_range(0, 2047)));
            ne = $urandom_range(0, 2);
            p1 = $urandom_range(0, 15);
            p2 = (p1 + $urandom_range(1, 15)) % 16;
            if (ne >= 1) cw[p1] = ~cw[p1];
            if (ne == 2) cw[p2] = ~cw[p2];
            exp = model_decode(cw);
            run_word(cw[7:0], cw[15:8], exp[7:0], exp[15:8], $urandom_range(0, 2));
        end

        // Saturation: 2^CNT_W+2 single-error words after a fresh reset.
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        exp_single = 0;
        exp_double = 0;
        for (int n = 0; n < 258; n++) run_word(8'hFE, 8'hFF, 8'hFF, 8'h47, 0);
        check("single_saturated", {24'd0, SingleCnt}, 32'h000000FF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
